// File: rtl/punc_pkg.sv
// Shared PUnC definitions: opcodes, controller states and datapath select encodings.
package punc_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned NZP_W = 3;
    localparam int unsigned SEL_W = 2;

    localparam logic [NZP_W-1:0] CC_RESET = 3'b010;

    // LC3 opcodes
    localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OP_W-1:0] OP_RSV  = 4'b1101;
    localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OP_W-1:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM1,
        ST_MEM2,
        ST_HALT
    } state_e;

    // PC source
    localparam logic [SEL_W-1:0] PC_SEL_BASE  = 2'd0;
    localparam logic [SEL_W-1:0] PC_SEL_OFF9  = 2'd1;
    localparam logic [SEL_W-1:0] PC_SEL_OFF11 = 2'd2;
    // ALU operand 1
    localparam logic [SEL_W-1:0] OP1_SEL_SR1  = 2'd0;
    localparam logic [SEL_W-1:0] OP1_SEL_PC   = 2'd1;
    localparam logic [SEL_W-1:0] OP1_SEL_BASE = 2'd2;
    // ALU operand 2
    localparam logic OP2_SEL_SR2 = 1'b0;
    localparam logic OP2_SEL_EXT = 1'b1;
    // sign-extension field
    localparam logic [SEL_W-1:0] EXT_SEL_IMM5  = 2'd0;
    localparam logic [SEL_W-1:0] EXT_SEL_OFF6  = 2'd1;
    localparam logic [SEL_W-1:0] EXT_SEL_OFF9  = 2'd2;
    localparam logic [SEL_W-1:0] EXT_SEL_OFF11 = 2'd3;
    // register write-back source
    localparam logic [SEL_W-1:0] RES_SEL_SUM = 2'd0;
    localparam logic [SEL_W-1:0] RES_SEL_AND = 2'd1;
    localparam logic [SEL_W-1:0] RES_SEL_NOT = 2'd2;
    localparam logic [SEL_W-1:0] RES_SEL_MEM = 2'd3;
    // MAR source
    localparam logic MAR_SEL_ALU = 1'b0;
    localparam logic MAR_SEL_MEM = 1'b1;

    // Datapath control word
    typedef struct packed {
        logic             ir_ld;
        logic             pc_inc;
        logic             pc_ld;
        logic [SEL_W-1:0] pc_sel;
        logic [SEL_W-1:0] op1_sel;
        logic             op2_sel;
        logic [SEL_W-1:0] extend_sel;
        logic [SEL_W-1:0] result_sel;
        logic             rf_w_en;
        logic             rf_w_r7;
        logic             mar_ld;
        logic             mar_sel;
        logic             mem_w_en;
    } ctrl_t;

endpackage

// File: rtl/punc_controller_if.sv
// Controller <-> datapath bundle: IR fields and result flags in, control word out.
interface punc_ctrl_if;
    import punc_pkg::*;

    logic [OP_W-1:0]  opcode;
    logic [NZP_W-1:0] ir_nzp;
    logic             ir_imm;
    logic             ir_jsr_long;
    logic             res_n;
    logic             res_z;
    logic             res_p;

    logic             ir_ld;
    logic             pc_inc;
    logic             pc_ld;
    logic [SEL_W-1:0] pc_sel;
    logic [SEL_W-1:0] op1_sel;
    logic             op2_sel;
    logic [SEL_W-1:0] extend_sel;
    logic [SEL_W-1:0] result_sel;
    logic             rf_w_en;
    logic             rf_w_r7;
    logic             mar_ld;
    logic             mar_sel;
    logic             mem_w_en;
    logic [NZP_W-1:0] cc;
    logic             halted;

    modport master (
        input  opcode, ir_nzp, ir_imm, ir_jsr_long, res_n, res_z, res_p,
        output ir_ld, pc_inc, pc_ld, pc_sel, op1_sel, op2_sel, extend_sel,
               result_sel, rf_w_en, rf_w_r7, mar_ld, mar_sel, mem_w_en, cc, halted
    );

    modport slave (
        output opcode, ir_nzp, ir_imm, ir_jsr_long, res_n, res_z, res_p,
        input  ir_ld, pc_inc, pc_ld, pc_sel, op1_sel, op2_sel, extend_sel,
               result_sel, rf_w_en, rf_w_r7, mar_ld, mar_sel, mem_w_en, cc, halted
    );

endinterface

// File: rtl/punc_branch_eval.sv
// N/Z/P condition-code register and branch-taken evaluation.
module punc_branch_eval
    import punc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cc_ld,
    input  logic [NZP_W-1:0] res_nzp,
    input  logic [NZP_W-1:0] ir_nzp,
    output logic [NZP_W-1:0] cc,
    output logic             taken
);

    logic [NZP_W-1:0] cc_q;
    logic [NZP_W-1:0] cc_d;

    // Capture write-back flags on the write-back cycle
    always_comb begin
        cc_d = cc_q;
        if (cc_ld) begin
            cc_d = res_nzp;
        end
    end

    // Condition-code register
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc    = cc_q;
    assign taken = |(ir_nzp & cc_q);

endmodule

// File: rtl/punc_controller.sv
// PUnC LC3 control unit: fetch/decode/execute/memory sequencing and datapath control.
// Optional build macro PUNC_TRAP_HALT_EN: TRAP stops the core in HALT until reset.
module punc_controller
    import punc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    punc_ctrl_if.master bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_c;
    ctrl_t  ctrl_out;
    logic   cc_ld;
    logic   taken;

    punc_branch_eval u_branch_eval (
        .clk     (clk),
        .rst     (rst),
        .cc_ld   (cc_ld),
        .res_nzp ({bus.res_n, bus.res_z, bus.res_p}),
        .ir_nzp  (bus.ir_nzp),
        .cc      (bus.cc),
        .taken   (taken)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore control decode from state plus IR fields
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        cc_ld   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ctrl_c.ir_ld = 1'b1;
                state_d      = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl_c.pc_inc = 1'b1;
                state_d       = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (bus.opcode)
                    OP_ADD, OP_AND: begin
                        ctrl_c.op1_sel    = OP1_SEL_SR1;
                        ctrl_c.op2_sel    = bus.ir_imm;
                        ctrl_c.extend_sel = EXT_SEL_IMM5;
                        ctrl_c.result_sel = (bus.opcode == OP_AND) ? RES_SEL_AND : RES_SEL_SUM;
                        ctrl_c.rf_w_en    = 1'b1;
                        cc_ld             = 1'b1;
                    end
                    OP_NOT: begin
                        ctrl_c.result_sel = RES_SEL_NOT;
                        ctrl_c.rf_w_en    = 1'b1;
                        cc_ld             = 1'b1;
                    end
                    OP_LEA: begin
                        ctrl_c.op1_sel    = OP1_SEL_PC;
                        ctrl_c.op2_sel    = OP2_SEL_EXT;
                        ctrl_c.extend_sel = EXT_SEL_OFF9;
                        ctrl_c.result_sel = RES_SEL_SUM;
                        ctrl_c.rf_w_en    = 1'b1;
                        cc_ld             = 1'b1;
                    end
                    OP_BR: begin
                        if (taken) begin
                            ctrl_c.pc_ld  = 1'b1;
                            ctrl_c.pc_sel = PC_SEL_OFF9;
                        end
                    end
                    OP_JMP: begin
                        ctrl_c.pc_ld  = 1'b1;
                        ctrl_c.pc_sel = PC_SEL_BASE;
                    end
                    OP_JSR: begin
                        // Link value is PC + 0; the datapath zeroes the offset while rf_w_r7 is set
                        ctrl_c.op1_sel    = OP1_SEL_PC;
                        ctrl_c.op2_sel    = OP2_SEL_EXT;
                        ctrl_c.extend_sel = EXT_SEL_IMM5;
                        ctrl_c.result_sel = RES_SEL_SUM;
                        ctrl_c.rf_w_en    = 1'b1;
                        ctrl_c.rf_w_r7    = 1'b1;
                        ctrl_c.pc_ld      = 1'b1;
                        ctrl_c.pc_sel     = bus.ir_jsr_long ? PC_SEL_OFF11 : PC_SEL_BASE;
                    end
                    OP_LD, OP_ST, OP_LDI, OP_STI: begin
                        ctrl_c.op1_sel    = OP1_SEL_PC;
                        ctrl_c.op2_sel    = OP2_SEL_EXT;
                        ctrl_c.extend_sel = EXT_SEL_OFF9;
                        ctrl_c.mar_ld     = 1'b1;
                        ctrl_c.mar_sel    = MAR_SEL_ALU;
                        state_d           = ST_MEM1;
                    end
                    OP_LDR, OP_STR: begin
                        ctrl_c.op1_sel    = OP1_SEL_BASE;
                        ctrl_c.op2_sel    = OP2_SEL_EXT;
                        ctrl_c.extend_sel = EXT_SEL_OFF6;
                        ctrl_c.mar_ld     = 1'b1;
                        ctrl_c.mar_sel    = MAR_SEL_ALU;
                        state_d           = ST_MEM1;
                    end
`ifdef PUNC_TRAP_HALT_EN
                    OP_TRAP: begin
                        state_d = ST_HALT;
                    end
`endif
                    default: begin
                    end
                endcase
            end
            ST_MEM1: begin
                state_d = ST_FETCH;
                case (bus.opcode)
                    OP_LD, OP_LDR: begin
                        ctrl_c.result_sel = RES_SEL_MEM;
                        ctrl_c.rf_w_en    = 1'b1;
                        cc_ld             = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        ctrl_c.mem_w_en = 1'b1;
                    end
                    OP_LDI, OP_STI: begin
                        ctrl_c.mar_ld  = 1'b1;
                        ctrl_c.mar_sel = MAR_SEL_MEM;
                        state_d        = ST_MEM2;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM2: begin
                state_d = ST_FETCH;
                case (bus.opcode)
                    OP_LDI: begin
                        ctrl_c.result_sel = RES_SEL_MEM;
                        ctrl_c.rf_w_en    = 1'b1;
                        cc_ld             = 1'b1;
                    end
                    OP_STI: begin
                        ctrl_c.mem_w_en = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Reset masks every control output so no write escapes the reset cycle
    assign ctrl_out = rst ? '0 : ctrl_c;

    assign bus.ir_ld      = ctrl_out.ir_ld;
    assign bus.pc_inc     = ctrl_out.pc_inc;
    assign bus.pc_ld      = ctrl_out.pc_ld;
    assign bus.pc_sel     = ctrl_out.pc_sel;
    assign bus.op1_sel    = ctrl_out.op1_sel;
    assign bus.op2_sel    = ctrl_out.op2_sel;
    assign bus.extend_sel = ctrl_out.extend_sel;
    assign bus.result_sel = ctrl_out.result_sel;
    assign bus.rf_w_en    = ctrl_out.rf_w_en;
    assign bus.rf_w_r7    = ctrl_out.rf_w_r7;
    assign bus.mar_ld     = ctrl_out.mar_ld;
    assign bus.mar_sel    = ctrl_out.mar_sel;
    assign bus.mem_w_en   = ctrl_out.mem_w_en;

`ifdef PUNC_TRAP_HALT_EN
    assign bus.halted = (state_q == ST_HALT) && !rst;
`else
    assign bus.halted = 1'b0;
`endif

endmodule
